// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ requesters.
// Each winner gets a grant cycle, then its data is loaded and an ack is returned.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [2:0]            owner,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        winner_reg, winner_next;
  logic [2:0]        last_reg, last_next;
  logic [2:0]        owner_reg, owner_next;
  logic [NREQ-1:0]   grant_reg, grant_next;
  logic [NREQ-1:0]   ack_reg, ack_next;
  logic [WIDTH-1:0]  q_reg, q_next;

  logic [WIDTH-1:0]  lane [NREQ];
  logic [NREQ-1:0]   onehot_one;
  logic [2:0]        pick;
  logic              found;
  int                idx;
  logic              win_req;
  logic [WIDTH-1:0]  win_data;

  assign onehot_one = {{(NREQ-1){1'b0}}, 1'b1};

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan from the requester after the last writer, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_reg) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = 3'(idx);
      end
    end
  end

  always_comb begin
    win_req  = 1'b0;
    win_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner_reg == 3'(k)) begin
        win_req  = req[k];
        win_data = lane[k];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    last_next   = last_reg;
    owner_next  = owner_reg;
    q_next      = q_reg;
    grant_next  = '0;
    ack_next    = '0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next  = GRANT;
          winner_next = pick;
          grant_next  = onehot_one << pick;
        end
      end
      GRANT: begin
        // A withdrawn request aborts without touching fairness state.
        if (win_req) begin
          state_next = WRITE;
          q_next     = win_data;
          owner_next = winner_reg;
          last_next  = winner_reg;
          ack_next   = onehot_one << winner_reg;
        end else begin
          state_next = IDLE;
        end
      end
      WRITE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      winner_reg <= '0;
      last_reg   <= 3'(NREQ-1);
      owner_reg  <= '0;
      q_reg      <= '0;
      grant_reg  <= '0;
      ack_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      winner_reg <= winner_next;
      last_reg   <= last_next;
      owner_reg  <= owner_next;
      q_reg      <= q_next;
      grant_reg  <= grant_next;
      ack_reg    <= ack_next;
    end
  end

  assign grant = grant_reg;
  assign ack   = ack_reg;
  assign q     = q_reg;
  assign owner = owner_reg;
  assign busy  = (state_reg != IDLE);

endmodule
